// File: rtl/gbt_frame_rx_if.sv
// gbt_frame_rx_if: bundles the elink word stream and the decoded request/status
// outputs of gbt_frame_rx.
//   gbt_rx_data_i  16        [15:12] TTC {l1a, calpulse, resync, bc0}, [11:0] payload
//   req_en_o       1         one-cycle write request strobe
//   req_addr_o     ADDR_W    request address, held until the next request
//   req_data_o     DATA_W    request data, held until the next request
//   locked_o       1         frame alignment acquired
//   err_cnt_o      ERR_CNT_W saturating frame error count
//   l1a_o, calpulse_o, resync_o, bc0_o   registered TTC decode
// Modports: master = receiver side (gbt_frame_rx), slave = stream source / request consumer.
interface gbt_frame_rx_if #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ERR_CNT_W = 16
) ();
  logic [15:0]          gbt_rx_data_i;
  logic                 req_en_o;
  logic [ADDR_W-1:0]    req_addr_o;
  logic [DATA_W-1:0]    req_data_o;
  logic                 locked_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;
  logic                 l1a_o;
  logic                 calpulse_o;
  logic                 resync_o;
  logic                 bc0_o;

  modport master (
    input  gbt_rx_data_i,
    output req_en_o, req_addr_o, req_data_o, locked_o, err_cnt_o,
    output l1a_o, calpulse_o, resync_o, bc0_o
  );

  modport slave (
    output gbt_rx_data_i,
    input  req_en_o, req_addr_o, req_data_o, locked_o, err_cnt_o,
    input  l1a_o, calpulse_o, resync_o, bc0_o
  );
endinterface

// File: rtl/gbt_frame_rx.sv
// gbt_frame_rx: parses the 16-bit-per-BX GBT downlink word stream into register
// write requests. Frame: BEGIN {wr_valid, wr_en, 2'b00, addr[MSB byte]},
// N_ADDR_WORDS x 12-bit address words (MSW first), N_DATA_WORDS data words
// (MSW first, first word contributes [7:0] only), END (payload == FRAME_END).
// Lock is declared after LOCK_FRAMES consecutive good frames; requests are only
// issued while locked. Bad END words bump a saturating error counter and
// send the parser back to hunting for a frame-end word.
//
// Ports:
//   ttc_clk_40_i  40 MHz TTC clock, rising edge
//   reset_i       asynchronous active-high reset
//   bus           gbt_frame_rx_if.master (stream in, request/status/TTC out)
//
// Optional feature, macro GBT_FRAME_RX_TTC_EN: when defined, the four TTC bits
// are registered onto l1a_o/calpulse_o/resync_o/bc0_o, and a registered resync
// forces the parser back to hunt and drops lock. When undefined those outputs
// are tied low and resync has no effect.
module gbt_frame_rx #(
  parameter int unsigned N_ADDR_WORDS = 2,
  parameter int unsigned N_DATA_WORDS = 3,
  parameter logic [11:0] FRAME_END    = 12'hABC,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter int unsigned ERR_CNT_W    = 16,
  localparam int unsigned ADDR_W      = 8 + 12 * N_ADDR_WORDS,
  localparam int unsigned DATA_W      = 12 * N_DATA_WORDS - 4
) (
  input  logic           ttc_clk_40_i,
  input  logic           reset_i,
  gbt_frame_rx_if.master bus
);

  localparam int unsigned MaxWords = (N_ADDR_WORDS > N_DATA_WORDS) ? N_ADDR_WORDS : N_DATA_WORDS;
  localparam int unsigned CntW     = (MaxWords > 1) ? $clog2(MaxWords) : 1;

  localparam logic [CntW-1:0] AddrLast = CntW'(N_ADDR_WORDS - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(N_DATA_WORDS - 1);
  localparam logic [3:0]      LockCnt  = 4'(LOCK_FRAMES);

  typedef enum logic [2:0] {
    StHunt,
    StBegin,
    StAddr,
    StData,
    StEnd
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0]    data_sh_q, data_sh_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 wr_en_q, wr_en_d;
  logic [3:0]           good_cnt_q, good_cnt_d;
  logic                 locked_q, locked_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 req_en_q, req_en_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [DATA_W-1:0]    req_data_q, req_data_d;

  logic [11:0]          payload;
  logic                 end_match;
  logic [ADDR_W-1:0]    addr_shifted;
  logic [DATA_W-1:0]    data_shifted;
  logic                 resync_hit;

  assign payload      = bus.gbt_rx_data_i[11:0];
  assign end_match    = (payload == FRAME_END);
  assign addr_shifted = {addr_sh_q[ADDR_W-13:0], payload};

  // A single data word yields only 8 bits, so there is nothing to shift into.
  if (DATA_W > 12) begin : g_data_shift
    assign data_shifted = {data_sh_q[DATA_W-13:0], payload};
  end else begin : g_data_narrow
    assign data_shifted = payload[DATA_W-1:0];
  end

`ifdef GBT_FRAME_RX_TTC_EN
  logic [3:0] ttc_q;

  always_ff @(posedge ttc_clk_40_i or posedge reset_i) begin
    if (reset_i) begin
      ttc_q <= 4'b0000;
    end else begin
      ttc_q <= bus.gbt_rx_data_i[15:12];
    end
  end

  assign bus.l1a_o      = ttc_q[3];
  assign bus.calpulse_o = ttc_q[2];
  assign bus.resync_o   = ttc_q[1];
  assign bus.bc0_o      = ttc_q[0];
  assign resync_hit     = ttc_q[1];
`else
  logic unused_ttc;

  assign unused_ttc     = ^bus.gbt_rx_data_i[15:12];
  assign bus.l1a_o      = 1'b0;
  assign bus.calpulse_o = 1'b0;
  assign bus.resync_o   = 1'b0;
  assign bus.bc0_o      = 1'b0;
  assign resync_hit     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    wr_valid_d = wr_valid_q;
    wr_en_d    = wr_en_q;
    good_cnt_d = good_cnt_q;
    // Lock follows the good-frame counter one cycle later.
    locked_d   = (good_cnt_q == LockCnt);
    err_cnt_d  = err_cnt_q;
    req_en_d   = 1'b0;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;

    if (resync_hit) begin
      state_d    = StHunt;
      cnt_d      = '0;
      good_cnt_d = 4'd0;
      locked_d   = 1'b0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (end_match) begin
            state_d = StBegin;
          end
        end

        StBegin: begin
          wr_valid_d = payload[11];
          wr_en_d    = payload[10];
          addr_sh_d  = ADDR_W'(payload[7:0]);
          cnt_d      = '0;
          state_d    = StAddr;
        end

        StAddr: begin
          addr_sh_d = addr_shifted;
          if (cnt_q == AddrLast) begin
            cnt_d   = '0;
            state_d = StData;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StData: begin
          data_sh_d = (cnt_q == '0) ? DATA_W'(payload[7:0]) : data_shifted;
          if (cnt_q == DataLast) begin
            cnt_d   = '0;
            state_d = StEnd;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StEnd: begin
          if (end_match) begin
            if (good_cnt_q != LockCnt) begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
            // Only frames seen while already locked may write.
            if (locked_q && wr_valid_q && wr_en_q) begin
              req_en_d   = 1'b1;
              req_addr_d = addr_sh_q;
              req_data_d = data_sh_q;
            end
            state_d = StBegin;
          end else begin
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            good_cnt_d = 4'd0;
            state_d    = StHunt;
          end
        end

        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge ttc_clk_40_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StHunt;
      cnt_q      <= '0;
      addr_sh_q  <= '0;
      data_sh_q  <= '0;
      wr_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      good_cnt_q <= 4'd0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
      req_en_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sh_q  <= addr_sh_d;
      data_sh_q  <= data_sh_d;
      wr_valid_q <= wr_valid_d;
      wr_en_q    <= wr_en_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      err_cnt_q  <= err_cnt_d;
      req_en_q   <= req_en_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

  assign bus.req_en_o   = req_en_q;
  assign bus.req_addr_o = req_addr_q;
  assign bus.req_data_o = req_data_q;
  assign bus.locked_o   = locked_q;
  assign bus.err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_gbt_frame_rx.sv
// Directed bench for gbt_frame_rx: a default-parameter instance (framing, lock,
// error, wr_en=0, TTC, async reset) and a small instance (1 address word,
// 2 data words, 2-bit error counter) for frame generalisation and saturation.
module tb_gbt_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gbt_frame_rx_if #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(16)) if1 ();
  gbt_frame_rx_if #(.ADDR_W(20), .DATA_W(20), .ERR_CNT_W(2))  if2 ();

  gbt_frame_rx dut1 (
    .ttc_clk_40_i (clk),
    .reset_i      (rst),
    .bus          (if1.master)
  );

  gbt_frame_rx #(
    .N_ADDR_WORDS (1),
    .N_DATA_WORDS (2),
    .ERR_CNT_W    (2)
  ) dut2 (
    .ttc_clk_40_i (clk),
    .reset_i      (rst),
    .bus          (if2.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one word, let it be sampled, then settle past the edge.
  task automatic w1(input logic [15:0] w);
    if1.gbt_rx_data_i = w;
    @(posedge clk);
    #1;
  endtask

  task automatic w2(input logic [15:0] w);
    if2.gbt_rx_data_i = w;
    @(posedge clk);
    #1;
  endtask

  // Default frame: beg, 000, a_last, 012, 345, d_last, endw.
  task automatic frame1(input logic [3:0] ttc, input logic [11:0] beg, input logic [11:0] a_last,
                        input logic [11:0] d_last, input logic [11:0] endw, input logic exp_req);
    logic [11:0] words [7];
    words[0] = beg;
    words[1] = 12'h000;
    words[2] = a_last;
    words[3] = 12'h012;
    words[4] = 12'h345;
    words[5] = d_last;
    words[6] = endw;
    for (int i = 0; i < 7; i++) begin
      w1({ttc, words[i]});
      chk("req_en1", if1.req_en_o, (i == 6) ? exp_req : 1'b0);
    end
  endtask

  // Small frame: beg, addr, d0, d1, endw.
  task automatic frame2(input logic [11:0] endw, input logic exp_req);
    logic [11:0] words [5];
    words[0] = 12'hCAB;
    words[1] = 12'h123;
    words[2] = 12'h0CD;
    words[3] = 12'hEF0;
    words[4] = endw;
    for (int i = 0; i < 5; i++) begin
      w2({4'h0, words[i]});
      chk("req_en2", if2.req_en_o, (i == 4) ? exp_req : 1'b0);
    end
  endtask

  initial begin
    if1.gbt_rx_data_i = 16'h0000;
    if2.gbt_rx_data_i = 16'h0000;
    #12;
    chk("rst_req_en", if1.req_en_o, 0);
    chk("rst_req_addr", if1.req_addr_o, 0);
    chk("rst_req_data", if1.req_data_o, 0);
    chk("rst_locked", if1.locked_o, 0);
    chk("rst_err", if1.err_cnt_o, 0);
    chk("rst_ttc", {if1.l1a_o, if1.calpulse_o, if1.resync_o, if1.bc0_o}, 0);
    chk("rst_err2", if2.err_cnt_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Acquire lock: hunt END, two good frames, then the request frame.
    w1(16'h0ABC);
    chk("hunt_locked", if1.locked_o, 0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    chk("good1_locked", if1.locked_o, 0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    chk("good2_locked_lat", if1.locked_o, 0);
    w1(16'h0C40);
    chk("good2_locked", if1.locked_o, 1);
    chk("no_req_yet_addr", if1.req_addr_o, 0);
    // Finish that frame from word 1 by hand; it is the first request frame.
    w1(16'h0000); w1(16'h0000); w1(16'h0012); w1(16'h0345); w1(16'h0678);
    chk("pre_req_en", if1.req_en_o, 0);
    w1(16'h0ABC);
    chk("req_en_pulse", if1.req_en_o, 1);
    chk("req_addr", if1.req_addr_o, 64'h4000_0000);
    chk("req_data", if1.req_data_o, 64'h1234_5678);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b1);

    // Corrupted END.
    frame1(4'h0, 12'hC40, 12'h000, 12'h999, 12'hABD, 1'b0);
    chk("bad_err", if1.err_cnt_o, 1);
    chk("bad_locked_same", if1.locked_o, 1);
    chk("bad_hold_data", if1.req_data_o, 64'h1234_5678);
    w1(16'h0000);
    chk("bad_locked_drop", if1.locked_o, 0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b1);
    chk("relock_locked", if1.locked_o, 1);
    chk("relock_err", if1.err_cnt_o, 1);

    // wr_en=0 frame: good, no request, outputs hold.
    frame1(4'h0, 12'h840, 12'h555, 12'h999, 12'hABC, 1'b0);
    chk("wren0_addr", if1.req_addr_o, 64'h4000_0000);
    chk("wren0_data", if1.req_data_o, 64'h1234_5678);
    chk("wren0_err", if1.err_cnt_o, 1);
    chk("wren0_locked", if1.locked_o, 1);
    frame1(4'h0, 12'hC41, 12'h001, 12'h111, 12'hABC, 1'b1);
    chk("req2_addr", if1.req_addr_o, 64'h4100_0001);
    chk("req2_data", if1.req_data_o, 64'h1234_5111);

`ifdef GBT_FRAME_RX_TTC_EN
    w1(16'hF000);
    chk("ttc_on", {if1.l1a_o, if1.calpulse_o, if1.resync_o, if1.bc0_o}, 4'hF);
    chk("ttc_resync_lock_lat", if1.locked_o, 1);
    w1(16'h0000);
    chk("ttc_off", {if1.l1a_o, if1.calpulse_o, if1.resync_o, if1.bc0_o}, 4'h0);
    chk("resync_locked", if1.locked_o, 0);
    chk("resync_err", if1.err_cnt_o, 1);
    w1(16'h2000);
    chk("resync_only", {if1.l1a_o, if1.calpulse_o, if1.resync_o, if1.bc0_o}, 4'h2);
`else
    // TTC bits must neither appear on the outputs nor disturb framing.
    frame1(4'hF, 12'hC40, 12'h003, 12'h333, 12'hABC, 1'b1);
    chk("ttc_tied", {if1.l1a_o, if1.calpulse_o, if1.resync_o, if1.bc0_o}, 4'h0);
    chk("ttc_ign_addr", if1.req_addr_o, 64'h4000_0003);
    chk("ttc_ign_data", if1.req_data_o, 64'h1234_5333);
    chk("ttc_ign_locked", if1.locked_o, 1);
`endif

    // Async reset in the middle of the data words.
    w1(16'h0C40); w1(16'h0000); w1(16'h0000); w1(16'h0012); w1(16'h0345);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", if1.req_addr_o, 0);
    chk("mid_rst_data", if1.req_data_o, 0);
    chk("mid_rst_locked", if1.locked_o, 0);
    chk("mid_rst_err", if1.err_cnt_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    w1(16'h0678);
    w1(16'h0ABC);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    frame1(4'h0, 12'hC40, 12'h000, 12'h678, 12'hABC, 1'b0);
    chk("post_rst_addr", if1.req_addr_o, 0);
    frame1(4'h0, 12'hC40, 12'h002, 12'h222, 12'hABC, 1'b1);
    chk("post_rst_req_addr", if1.req_addr_o, 64'h4000_0002);
    chk("post_rst_req_data", if1.req_data_o, 64'h1234_5222);

    // Small frame instance.
    w2(16'h0ABC);
    frame2(12'hABC, 1'b0);
    frame2(12'hABC, 1'b0);
    frame2(12'hABC, 1'b1);
    chk("small_addr", if2.req_addr_o, 64'hAB123);
    chk("small_data", if2.req_data_o, 64'hCDEF0);
    frame2(12'hABD, 1'b0);
    chk("sat_err_1", if2.err_cnt_o, 1);
    for (int k = 2; k <= 5; k++) begin
      w2(16'h0ABC);
      frame2(12'hABD, 1'b0);
      chk("sat_err", if2.err_cnt_o, (k < 3) ? k : 3);
    end
    chk("sat_hold_addr", if2.req_addr_o, 64'hAB123);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gbt_frame_rx.md
Name: gbt_frame_rx

Overview:
- Parametrised successor of the GBT elink request receiver.
- Parses the 16-bit-per-BX downlink word stream on the 40 MHz TTC clock into register write requests.
- Frame format is generalised: address and data word counts are configurable. Adds frame-end lock acquisition, error counting and a lock indicator.
- Sits between the elink deserializer/delay stage and the wishbone request master in the control path.

Parameters:
- N_ADDR_WORDS, 2, 12-bit address words after the begin word; ADDR_W = 8 + 12*N_ADDR_WORDS (32 at default).
- N_DATA_WORDS, 3, 12-bit data words; DATA_W = 12*N_DATA_WORDS - 4 (32 at default).
- FRAME_END, 12'hABC, payload value of the frame-end word.
- LOCK_FRAMES, 2, consecutive good frames needed to assert lock (1..15).
- ERR_CNT_W, 16, width of the saturating error counter.

Ports:
- ttc_clk_40_i  in  1  40 MHz TTC clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- gbt_rx_data_i  in  16  [15:12] TTC {l1a, calpulse, resync, bc0}; [11:0] frame payload.
- req_en_o  out  1  one-cycle write request strobe.
- req_addr_o  out  ADDR_W  request address; held until the next request.
- req_data_o  out  DATA_W  request data; held until the next request.
- locked_o  out  1  frame alignment acquired.
- err_cnt_o  out  ERR_CNT_W  saturating count of frame errors.
- l1a_o, calpulse_o, resync_o, bc0_o  out  1 each  registered TTC decode (see Optional Feature).

Behaviour:
- Reset (async): all outputs 0, state HUNT, good-frame counter 0, shift registers 0.
- Frame word order: BEGIN {wr_valid, wr_en, 2'b00, addr[ADDR_W-1:ADDR_W-8]}; then N_ADDR_WORDS address words, MSW first; then N_DATA_WORDS data words, MSW first; then END.
  - The first data word carries 4'b0 in [11:8] and data[DATA_W-1:DATA_W-8] in [7:0].
- States: HUNT, BEGIN, ADDR, DATA, END. A word counter indexes ADDR and DATA.
- HUNT: payload == FRAME_END -> BEGIN; otherwise stay in HUNT. No error is counted in HUNT.
- BEGIN: latch wr_valid and wr_en, and latch [7:0] as addr MSB. -> ADDR.
- ADDR: shift 12 bits into the address. After N_ADDR_WORDS words -> DATA.
- DATA: shift into the data register; the first word contributes its [7:0] only. After N_DATA_WORDS words -> END.
- END with payload == FRAME_END (good frame):
  - Good counter increments, saturating at LOCK_FRAMES.
  - locked_o rises on the cycle after the counter reaches LOCK_FRAMES.
  - If locked_o was already 1 when the END word was sampled, and wr_valid & wr_en are both set: req_addr_o and req_data_o update, and req_en_o pulses for exactly one cycle on the following edge. Latency from END word sample to req_en_o is 1 cycle.
  - Next state is BEGIN.
- END with payload != FRAME_END (bad frame):
  - err_cnt_o increments, saturating at all-ones.
  - Good counter clears; locked_o drops on the next cycle.
  - State -> HUNT. No request is issued.
- Frames with wr_valid=0 or wr_en=0 are good frames but issue no request.
- A bad frame never emits partially assembled addr/data; the output registers keep their last good values.
- Reset asserted mid-frame aborts immediately. After release, the block re-hunts and needs LOCK_FRAMES good frames again.
- TTC bits are ignored by the parser and do not affect framing.

Optional Feature:
- Macro: GBT_FRAME_RX_TTC_EN.
- Defined: l1a_o, calpulse_o, resync_o and bc0_o are gbt_rx_data_i[15], [14], [13] and [12] registered on every cycle regardless of state, with 1-cycle latency.
- Defined: resync_o=1 also forces the parser to HUNT and clears lock, without incrementing err_cnt_o.
- Not defined: all four outputs are tied to 0 and resync has no effect on the parser.

Test Plan:
- Default params; stream 7-word frames of 0x0C40, 0x0000, 0x0000, 0x0012, 0x0345, 0x0678, 0x0ABC (TTC bits 0), repeated -> locked_o=1 after the 2nd END. The 3rd frame gives req_en_o one-cycle pulse with req_addr_o=0x40000000, req_data_o=0x12345678.
- Locked stream; corrupt one END word to 0x0ABD -> err_cnt_o=1, locked_o falls next cycle, no req_en_o for that frame. Relock after 1 hunt END plus 2 good frames; the request resumes on the following frame.
- Locked stream with BEGIN word 0x0840 (wr_en=0) -> no req_en_o; outputs hold their previous values; err_cnt_o unchanged.
- Assert reset_i asynchronously during the DATA words -> all outputs 0 immediately; no request is emitted after release until relock.
- ERR_CNT_W=2; inject 5 bad frames -> err_cnt_o saturates at 3.
- GBT_FRAME_RX_TTC_EN defined; drive 0xF000|payload on every word -> all four TTC outputs high with 1-cycle delay. A single word with only bit 13 set drops locked_o with err_cnt_o unchanged. N_ADDR_WORDS=1, N_DATA_WORDS=2: frame 0x0CAB, 0x0123, 0x00CD, 0x0EF0, 0x0ABC -> req_addr_o=0xAB123, req_data_o=0xCDEF0.
